// File: rtl/xfer_sample_sequencer.sv
// -----------------------------------------------------------------------------
// xfer_sample_sequencer
//
// Moves one L1A event at a time from the per-channel sample FIFO bank into
// the ring buffer. Event-ready pulses (RDY) are queued in a small pending
// counter. For each queued event the sequencer does the following:
//   - pops the L1A/header FIFO with a one-cycle L1A_RD_EN;
//   - waits until every used sample FIFO holds data;
//   - reads the FIFOs channel-major: NSAMP samples of channel 0, then
//     channel 1, and so on.
// RDENA is a contiguous NCHAN*NSAMP-cycle burst. RB_WADDR is the ring-buffer
// address paired with each RDENA cycle. The downstream mux/write stage delays
// both by two clocks to form its write enable.
//
// Optional feature (compile-time macro XFER_SEQ_ERRCNT_EN):
//   defined   -> ERRCNT is a 16-bit saturating count of UNDERRUN pulses
//   undefined -> ERRCNT is tied to zero and no counter is built
//
// Parameters
//   NCHAN   channels read per event (1..16)
//   NSAMP   samples per channel per event (1..255)
//   RB_AW   ring-buffer address width
//   PEND_W  pending-event counter width
//
// Ports
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   JTAG_MODE  in   JTAG readout owns the FIFOs; sequencer aborts / idles
//   RDY        in   1-clk pulse: one new event complete in the sample FIFOs
//   F16_MT     in   per-channel FIFO empty flags
//   CHAN       out  channel currently being read
//   RDENA      out  read strobe for FIFO CHAN
//   L1A_RD_EN  out  1-clk pulse: pop the L1A/header FIFO
//   RB_WADDR   out  ring-buffer address paired with RDENA
//   XSTATE     out  FSM state code (debug)
//   BUSY       out  high in every state except IDLE and JTAG
//   PEND       out  number of queued events
//   PEND_OVF   out  sticky: RDY arrived while PEND was at its maximum
//   UNDERRUN   out  1-clk pulse: a read was issued to an empty FIFO
//   ERRCNT     out  underrun count (zero unless XFER_SEQ_ERRCNT_EN)
//
// All outputs are registered; RST returns every output to zero.
// -----------------------------------------------------------------------------
module xfer_sample_sequencer #(
    parameter int NCHAN  = 16,
    parameter int NSAMP  = 8,
    parameter int RB_AW  = 11,
    parameter int PEND_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              JTAG_MODE,
    input  logic              RDY,
    input  logic [15:0]       F16_MT,
    output logic [3:0]        CHAN,
    output logic              RDENA,
    output logic              L1A_RD_EN,
    output logic [RB_AW-1:0]  RB_WADDR,
    output logic [2:0]        XSTATE,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND,
    output logic              PEND_OVF,
    output logic              UNDERRUN,
    output logic [15:0]       ERRCNT
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1A  = 3'd1,
        ST_CHK  = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4,
        ST_JTAG = 3'd5
    } state_t;

    localparam logic [3:0]        CHAN_LAST = 4'(NCHAN - 1);
    localparam logic [7:0]        SAMP_LAST = 8'(NSAMP - 1);
    localparam logic [3:0]        CHAN_ONE  = 4'd1;
    localparam logic [7:0]        SAMP_ONE  = 8'd1;
    localparam logic [RB_AW-1:0]  WADDR_ONE = RB_AW'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    // Only the FIFOs of channels actually read take part in the "all ready" test.
    localparam logic [15:0]       CH_MASK   = (NCHAN >= 16) ? 16'hFFFF
                                                            : 16'((1 << NCHAN) - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        scnt;
    logic [7:0]        scnt_nxt;
    logic [3:0]        chan_nxt;
    logic              rdena_nxt;
    logic              l1a_nxt;
    logic              busy_nxt;
    logic              underrun_nxt;
    logic              last_smp;
    logic              fifos_ready;
    logic              pend_dec;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;

    assign XSTATE      = state;
    assign last_smp    = (scnt == SAMP_LAST) && (CHAN == CHAN_LAST);
    assign fifos_ready = ((F16_MT & CH_MASK) == 16'h0000);

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            scnt      <= '0;
            CHAN      <= '0;
            RDENA     <= 1'b0;
            L1A_RD_EN <= 1'b0;
            BUSY      <= 1'b0;
            UNDERRUN  <= 1'b0;
            RB_WADDR  <= '0;
            PEND      <= '0;
            PEND_OVF  <= 1'b0;
        end else begin
            state     <= state_nxt;
            scnt      <= scnt_nxt;
            CHAN      <= chan_nxt;
            RDENA     <= rdena_nxt;
            L1A_RD_EN <= l1a_nxt;
            BUSY      <= busy_nxt;
            UNDERRUN  <= underrun_nxt;
            PEND      <= pend_nxt;
            PEND_OVF  <= ovf_nxt;
            // The address advances after every read cycle, so the next read
            // (even of the next event) lands on the following slot.
            if (RDENA) begin
                RB_WADDR <= RB_WADDR + WADDR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        // JTAG ownership wins from any state; an event in flight is dropped.
        if (JTAG_MODE && (state != ST_JTAG)) begin
            state_nxt = ST_JTAG;
        end else begin
            unique case (state)
                ST_IDLE: if (PEND != '0) state_nxt = ST_L1A;
                ST_L1A:  state_nxt = ST_CHK;
                ST_CHK:  if (fifos_ready) state_nxt = ST_XFER;
                ST_XFER: if (last_smp) state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                ST_JTAG: if (!JTAG_MODE) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic (values loaded into the output registers at the next edge)
    // -------------------------------------------------------------------------
    always_comb begin
        chan_nxt     = '0;
        scnt_nxt     = '0;
        rdena_nxt    = (state_nxt == ST_XFER);
        l1a_nxt      = (state_nxt == ST_L1A);
        busy_nxt     = (state_nxt == ST_L1A) || (state_nxt == ST_CHK) ||
                       (state_nxt == ST_XFER) || (state_nxt == ST_DONE);
        underrun_nxt = (state == ST_XFER) && F16_MT[CHAN];

        // Entering XFER from CHK leaves channel and sample at zero.
        if ((state == ST_XFER) && (state_nxt == ST_XFER)) begin
            if (scnt == SAMP_LAST) begin
                scnt_nxt = '0;
                chan_nxt = CHAN + CHAN_ONE;
            end else begin
                scnt_nxt = scnt + SAMP_ONE;
                chan_nxt = CHAN;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending-event counter
    // -------------------------------------------------------------------------
    assign pend_dec = (state == ST_L1A);

    always_comb begin
        pend_nxt = PEND;
        ovf_nxt  = PEND_OVF;
        if (RDY && !pend_dec) begin
            if (PEND == PEND_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_nxt = PEND + PEND_ONE;
            end
        end else if (!RDY && pend_dec) begin
            pend_nxt = PEND - PEND_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Optional underrun counter
    // -------------------------------------------------------------------------
`ifdef XFER_SEQ_ERRCNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] errcnt_q;

    // Counts on the same edge that raises UNDERRUN, so the two stay aligned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            errcnt_q <= '0;
        end else if (underrun_nxt) begin
            errcnt_q <= sat_inc16(errcnt_q);
        end
    end

    assign ERRCNT = errcnt_q;
`else
    assign ERRCNT = 16'h0000;
`endif

endmodule

// File: tb/tb_xfer_sample_sequencer.sv
module tb_xfer_sample_sequencer;

    localparam int NCHAN  = 16;
    localparam int NSAMP  = 8;
    localparam int RB_AW  = 7;
    localparam int PEND_W = 2;
    localparam int NXF    = NCHAN * NSAMP;
    localparam int WMOD   = 1 << RB_AW;
    localparam int PMAX   = (1 << PEND_W) - 1;
    localparam logic [15:0] CH_MASK = (NCHAN >= 16) ? 16'hFFFF : 16'((1 << NCHAN) - 1);

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              JTAG_MODE = 1'b0;
    logic              RDY = 1'b0;
    logic [15:0]       F16_MT = 16'h0000;
    logic [3:0]        CHAN;
    logic              RDENA;
    logic              L1A_RD_EN;
    logic [RB_AW-1:0]  RB_WADDR;
    logic [2:0]        XSTATE;
    logic              BUSY;
    logic [PEND_W-1:0] PEND;
    logic              PEND_OVF;
    logic              UNDERRUN;
    logic [15:0]       ERRCNT;

    always #5 CLK = ~CLK;

    xfer_sample_sequencer #(
        .NCHAN (NCHAN),
        .NSAMP (NSAMP),
        .RB_AW (RB_AW),
        .PEND_W(PEND_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .JTAG_MODE(JTAG_MODE),
        .RDY      (RDY),
        .F16_MT   (F16_MT),
        .CHAN     (CHAN),
        .RDENA    (RDENA),
        .L1A_RD_EN(L1A_RD_EN),
        .RB_WADDR (RB_WADDR),
        .XSTATE   (XSTATE),
        .BUSY     (BUSY),
        .PEND     (PEND),
        .PEND_OVF (PEND_OVF),
        .UNDERRUN (UNDERRUN),
        .ERRCNT   (ERRCNT)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase numbers are the documented XSTATE codes, the
    // transfer is tracked as a flat read index k (channel = k / NSAMP).
    int m_ph, m_k, m_pend, m_waddr, m_err;
    bit m_ovf, m_und;

    task automatic model_step();
        int  pend_now;
        bit  dec;
        if (RST) begin
            m_ph = 0; m_k = 0; m_pend = 0; m_ovf = 0; m_waddr = 0; m_und = 0; m_err = 0;
            return;
        end
        pend_now = m_pend;
        dec = (m_ph == 1);
        if (RDY && !dec) begin
            if (m_pend == PMAX) m_ovf = 1;
            else m_pend++;
        end else if (!RDY && dec) begin
            m_pend--;
        end
        m_und = (m_ph == 3) && F16_MT[4'(m_k / NSAMP)];
        if (m_und && m_err < 65535) m_err++;
        if (m_ph == 3) m_waddr = (m_waddr + 1) % WMOD;
        if (JTAG_MODE && m_ph != 5) m_ph = 5;
        else begin
            case (m_ph)
                0: if (pend_now != 0) m_ph = 1;
                1: m_ph = 2;
                2: if ((F16_MT & CH_MASK) == 16'h0) begin m_ph = 3; m_k = 0; end
                3: if (m_k == NXF - 1) m_ph = 4; else m_k++;
                4: m_ph = 0;
                default: if (!JTAG_MODE) m_ph = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        int exp_err;
`ifdef XFER_SEQ_ERRCNT_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        chk("XSTATE",    32'(XSTATE),    32'(m_ph));
        chk("CHAN",      32'(CHAN),      (m_ph == 3) ? 32'(m_k / NSAMP) : 32'd0);
        chk("RDENA",     32'(RDENA),     32'(m_ph == 3));
        chk("L1A_RD_EN", 32'(L1A_RD_EN), 32'(m_ph == 1));
        chk("RB_WADDR",  32'(RB_WADDR),  32'(m_waddr));
        chk("BUSY",      32'(BUSY),      32'(m_ph >= 1 && m_ph <= 4));
        chk("PEND",      32'(PEND),      32'(m_pend));
        chk("PEND_OVF",  32'(PEND_OVF),  32'(m_ovf));
        chk("UNDERRUN",  32'(UNDERRUN),  32'(m_und));
        chk("ERRCNT",    32'(ERRCNT),    32'(exp_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        RST = 1'b1; RDY = 1'b0; JTAG_MODE = 1'b0; F16_MT = 16'h0;
        tick();
        RST = 1'b0;
    endtask

    typedef struct {
        logic        rst, rdy, jtag;
        logic [15:0] f16;
        logic [2:0]  xs;
        logic [3:0]  chan;
        logic        rdena, l1a;
        logic [6:0]  waddr;
        logic        busy;
        logic [1:0]  pend;
        logic        ovf;
    } vec_t;

    vec_t vt[16];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int g, n_l1a, n_rd, n_und, bad;
        int exp_err;

        //           rst rdy jt f16      xs ch rd l1 wa bs pd ov
        vt[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[2]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 1, 1, 0};
        vt[3]  = '{0, 0, 0, 16'h0000, 2, 0, 0, 0, 0, 1, 0, 0};
        vt[4]  = '{0, 0, 0, 16'h0000, 3, 0, 1, 0, 0, 1, 0, 0};
        vt[5]  = '{0, 0, 0, 16'h0000, 3, 0, 1, 0, 1, 1, 0, 0};
        vt[6]  = '{0, 1, 0, 16'h0000, 3, 0, 1, 0, 2, 1, 1, 0};
        vt[7]  = '{0, 0, 1, 16'h0000, 5, 0, 0, 0, 3, 0, 1, 0};
        vt[8]  = '{0, 1, 1, 16'h0000, 5, 0, 0, 0, 3, 0, 2, 0};
        vt[9]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 3, 0, 2, 0};
        vt[10] = '{0, 0, 0, 16'h0000, 1, 0, 0, 1, 3, 1, 2, 0};
        vt[11] = '{0, 1, 0, 16'h0000, 2, 0, 0, 0, 3, 1, 2, 0};
        vt[12] = '{0, 0, 0, 16'h0004, 2, 0, 0, 0, 3, 1, 2, 0};
        vt[13] = '{0, 0, 0, 16'h0000, 3, 0, 1, 0, 3, 1, 2, 0};
        vt[14] = '{0, 0, 0, 16'h0000, 3, 0, 1, 0, 4, 1, 2, 0};
        vt[15] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            RST = vt[i].rst; RDY = vt[i].rdy; JTAG_MODE = vt[i].jtag; F16_MT = vt[i].f16;
            tick();
            chk($sformatf("vec%0d_xstate", i), 32'(XSTATE),    32'(vt[i].xs));
            chk($sformatf("vec%0d_chan", i),   32'(CHAN),      32'(vt[i].chan));
            chk($sformatf("vec%0d_rdena", i),  32'(RDENA),     32'(vt[i].rdena));
            chk($sformatf("vec%0d_l1a", i),    32'(L1A_RD_EN), 32'(vt[i].l1a));
            chk($sformatf("vec%0d_waddr", i),  32'(RB_WADDR),  32'(vt[i].waddr));
            chk($sformatf("vec%0d_busy", i),   32'(BUSY),      32'(vt[i].busy));
            chk($sformatf("vec%0d_pend", i),   32'(PEND),      32'(vt[i].pend));
            chk($sformatf("vec%0d_ovf", i),    32'(PEND_OVF),  32'(vt[i].ovf));
        end
        RST = 1'b0; RDY = 1'b0; JTAG_MODE = 1'b0; F16_MT = 16'h0;

        // One event: one header pop, 128 contiguous channel-major reads.
        do_reset();
        RDY = 1'b1; tick(); RDY = 1'b0;
        n_l1a = 0; g = 0;
        while (!RDENA && g < 20) begin tick(); n_l1a += int'(L1A_RD_EN); g++; end
        chk("t1_l1a_pulses", 32'(n_l1a), 32'd1);
        chk("t1_first_rdena", 32'(RDENA), 32'd1);
        bad = 0;
        for (int i = 0; i < NXF; i++) begin
            if (RDENA !== 1'b1 || int'(CHAN) != i / NSAMP || int'(RB_WADDR) != i % WMOD) bad++;
            tick();
        end
        chk("t1_burst_errors", 32'(bad), 32'd0);
        chk("t1_done_rdena", 32'(RDENA), 32'd0);
        chk("t1_done_state", 32'(XSTATE), 32'd4);
        tick();
        chk("t1_busy_fall", 32'(BUSY), 32'd0);
        chk("t1_waddr_end", 32'(RB_WADDR), 32'(NXF % WMOD));

        // Three queued events run back to back; address wraps at 2^RB_AW.
        do_reset();
        JTAG_MODE = 1'b1; tick();
        RDY = 1'b1;
        tick(); chk("t2_pend1", 32'(PEND), 32'd1);
        tick(); chk("t2_pend2", 32'(PEND), 32'd2);
        tick(); chk("t2_pend3", 32'(PEND), 32'd3);
        RDY = 1'b0; JTAG_MODE = 1'b0;
        n_rd = 0; n_l1a = 0; g = 0;
        while (!(n_rd == 3 * NXF && XSTATE == 3'd0) && g < 3 * (NXF + 20)) begin
            tick(); n_rd += int'(RDENA); n_l1a += int'(L1A_RD_EN); g++;
        end
        chk("t2_reads", 32'(n_rd), 32'(3 * NXF));
        chk("t2_l1a", 32'(n_l1a), 32'd3);
        chk("t2_waddr", 32'(RB_WADDR), 32'((3 * NXF) % WMOD));
        chk("t2_pend0", 32'(PEND), 32'd0);
        chk("t2_ovf", 32'(PEND_OVF), 32'd0);

        // CHK hold for 10 clocks, then underruns on channel 5.
        do_reset();
        F16_MT = 16'h0004; RDY = 1'b1; tick(); RDY = 1'b0;
        g = 0;
        while (XSTATE != 3'd2 && g < 10) begin tick(); g++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (XSTATE != 3'd2) bad++;
            if (i == 9) F16_MT = 16'h0000;
            tick();
        end
        chk("t4_chk_hold", 32'(bad), 32'd0);
        chk("t4_xfer_after", 32'(XSTATE), 32'd3);
        g = 0;
        while (!(RDENA && CHAN == 4'd5) && g < 200) begin tick(); g++; end
        chk("t4_reach_ch5", 32'(CHAN), 32'd5);
        n_und = 0;
        F16_MT = 16'h0020;
        for (int i = 0; i < 3; i++) begin tick(); n_und += int'(UNDERRUN); end
        F16_MT = 16'h0000;
        g = 0;
        while (XSTATE != 3'd0 && g < 200) begin tick(); n_und += int'(UNDERRUN); g++; end
        chk("t4_underruns", 32'(n_und), 32'd3);
`ifdef XFER_SEQ_ERRCNT_EN
        exp_err = 3;
`else
        exp_err = 0;
`endif
        chk("t4_errcnt", 32'(ERRCNT), 32'(exp_err));

        // JTAG abort at the 40th read; event is dropped, address kept.
        do_reset();
        RDY = 1'b1; tick(); RDY = 1'b0;
        g = 0;
        while (!(RDENA && RB_WADDR == 7'd39) && g < 100) begin tick(); g++; end
        chk("t5_40th_read", 32'(RB_WADDR), 32'd39);
        JTAG_MODE = 1'b1; tick();
        chk("t5_abort_rdena", 32'(RDENA), 32'd0);
        chk("t5_abort_state", 32'(XSTATE), 32'd5);
        chk("t5_abort_waddr", 32'(RB_WADDR), 32'd40);
        tick(); tick(); tick();
        JTAG_MODE = 1'b0;
        n_rd = 0;
        for (int i = 0; i < 6; i++) begin tick(); n_rd += int'(RDENA); end
        chk("t5_no_resume", 32'(n_rd), 32'd0);
        chk("t5_idle", 32'(XSTATE), 32'd0);
        RDY = 1'b1; tick(); RDY = 1'b0;
        g = 0;
        while (!RDENA && g < 20) begin tick(); g++; end
        chk("t5_next_start", 32'(RB_WADDR), 32'd40);

        // Overflow while in JTAG, then reset in the middle of a transfer.
        do_reset();
        JTAG_MODE = 1'b1;
        for (int i = 0; i < 8; i++) begin RDY = 1'b1; tick(); RDY = 1'b0; tick(); end
        chk("t6_pend_max", 32'(PEND), 32'(PMAX));
        chk("t6_ovf", 32'(PEND_OVF), 32'd1);
        JTAG_MODE = 1'b0;
        g = 0;
        while (!RDENA && g < 20) begin tick(); g++; end
        for (int i = 0; i < 20; i++) tick();
        chk("t6_mid_xfer", 32'(RDENA), 32'd1);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("t6_rst_state", 32'(XSTATE), 32'd0);
        chk("t6_rst_rdena", 32'(RDENA), 32'd0);
        chk("t6_rst_chan", 32'(CHAN), 32'd0);
        chk("t6_rst_waddr", 32'(RB_WADDR), 32'd0);
        chk("t6_rst_pend", 32'(PEND), 32'd0);
        chk("t6_rst_ovf", 32'(PEND_OVF), 32'd0);
        chk("t6_rst_busy", 32'(BUSY), 32'd0);
        chk("t6_rst_errcnt", 32'(ERRCNT), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        g = 0;
        for (int i = 0; i < 8000; i++) begin
            RDY = ($urandom_range(0, 9) == 0);
            F16_MT = ($urandom_range(0, 24) == 0) ? 16'($urandom) : 16'h0000;
            if (g > 0) g--;
            else if ($urandom_range(0, 499) == 0) g = $urandom_range(1, 20);
            JTAG_MODE = (g != 0);
            RST = ($urandom_range(0, 3999) == 0);
            tick();
        end
        RST = 1'b0; RDY = 1'b0; JTAG_MODE = 1'b0; F16_MT = 16'h0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
